sha256_block_sequencer: RTL and testbench

Controller that feeds multi-block messages into one `sha256_core` instance and sequences each compression. It accepts padded 512-bit blocks over a valid/ready handshake and issues a one-cycle `input_valid` start to the core. It holds the block and chaining value stable while the core runs, and feeds each intermediate hash back as the next block's `Hash_in`. It returns the final 256-bit digest over a second valid/ready handshake, with a watchdog and message/block counters.

---
 rtl/sha256_pkg.sv | 17 +
 rtl/sha256_seq_watchdog.sv | 29 ++
 rtl/sha256_block_sequencer.sv | 138 +++++++++++++
 tb/tb_sha256_block_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 block sequencer.
package sha256_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;

  localparam logic [DIGEST_W-1:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sha256_seq_watchdog.sv
// Clearable RUN-cycle counter; expired flags TIMEOUT-1 cycles spent waiting on the core.
module sha256_seq_watchdog #(
  parameter int TIMEOUT = 72
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_reg;

  // Saturates at the expiry point so a stalled exit can never wrap back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/sha256_block_sequencer.sv
// Feeds padded blocks into an external sha256_core, chains intermediate hashes
// and returns the final digest over a valid/ready handshake.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 72
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [BLOCK_W-1:0]  blk_data,
  input  logic                blk_last,
  output logic                core_input_valid,
  output logic [DIGEST_W-1:0] core_hash_in,
  output logic [BLOCK_W-1:0]  core_data_in,
  input  logic                core_output_valid,
  input  logic [DIGEST_W-1:0] core_hash_out,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_err,
  output logic                busy,
  output logic [CNT_W-1:0]    msg_count,
  output logic [CNT_W-1:0]    blk_count
);

  seq_state_t          state_reg;
  logic                first_reg;
  logic                last_reg;
  logic [BLOCK_W-1:0]  data_reg;
  logic [DIGEST_W-1:0] h_reg;
  logic [DIGEST_W-1:0] digest_reg;
  logic                digest_err_reg;
  logic [CNT_W-1:0]    msg_count_reg;
  logic [CNT_W-1:0]    blk_count_reg;
  logic                blk_ready_reg;
  logic                core_input_valid_reg;
  logic                digest_valid_reg;
  logic                busy_reg;
  logic                wd_expired;

  sha256_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg == ST_START),
    .enable  (state_reg == ST_RUN),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg            <= ST_IDLE;
      first_reg            <= 1'b1;
      last_reg             <= 1'b0;
      data_reg             <= '0;
      h_reg                <= '0;
      digest_reg           <= '0;
      digest_err_reg       <= 1'b0;
      msg_count_reg        <= '0;
      blk_count_reg        <= '0;
      blk_ready_reg        <= 1'b1;
      core_input_valid_reg <= 1'b0;
      digest_valid_reg     <= 1'b0;
      busy_reg             <= 1'b0;
    end else begin
      core_input_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (blk_valid) begin
            data_reg             <= blk_data;
            last_reg             <= blk_last;
            blk_ready_reg        <= 1'b0;
            core_input_valid_reg <= 1'b1;
            busy_reg             <= 1'b1;
            state_reg            <= ST_START;
          end
        end
        // The core's round counter may still read 64 here, so its valid is not trusted yet.
        ST_START: begin
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (core_output_valid) begin
            h_reg         <= core_hash_out;
            first_reg     <= 1'b0;
            blk_count_reg <= blk_count_reg + CNT_W'(1);
            if (last_reg) begin
              digest_reg       <= core_hash_out;
              digest_valid_reg <= 1'b1;
              state_reg        <= ST_OUT;
            end else begin
              blk_ready_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end
          end else if (wd_expired) begin
            digest_reg       <= '0;
            digest_err_reg   <= 1'b1;
            digest_valid_reg <= 1'b1;
            state_reg        <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (digest_ready) begin
            first_reg <= 1'b1;
            if (!digest_err_reg) begin
              msg_count_reg <= msg_count_reg + CNT_W'(1);
            end
            digest_err_reg   <= 1'b0;
            digest_valid_reg <= 1'b0;
            blk_ready_reg    <= 1'b1;
            busy_reg         <= 1'b0;
            state_reg        <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Hash_out is combinational in Hash_in, so both core inputs come straight from held registers.
  assign core_hash_in     = first_reg ? SHA256_IV : h_reg;
  assign core_data_in     = data_reg;
  assign core_input_valid = core_input_valid_reg;
  assign blk_ready        = blk_ready_reg;
  assign digest_valid     = digest_valid_reg;
  assign digest           = digest_reg;
  assign digest_err       = digest_err_reg;
  assign busy             = busy_reg;
  assign msg_count        = msg_count_reg;
  assign blk_count        = blk_count_reg;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer with a behavioural SHA-256 core model.
module tb_sha256_block_sequencer;
  import sha256_pkg::*;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 72;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [511:0]  blk_data = '0;
  logic          blk_last = 1'b0;
  logic          core_input_valid;
  logic [255:0]  core_hash_in;
  logic [511:0]  core_data_in;
  logic          core_output_valid;
  logic [255:0]  core_hash_out = '0;
  logic          digest_valid;
  logic          digest_ready = 1'b1;
  logic [255:0]  digest;
  logic          digest_err;
  logic          busy;
  logic [CNT_W-1:0] msg_count;
  logic [CNT_W-1:0] blk_count;

  sha256_block_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .blk_valid         (blk_valid),
    .blk_ready         (blk_ready),
    .blk_data          (blk_data),
    .blk_last          (blk_last),
    .core_input_valid  (core_input_valid),
    .core_hash_in      (core_hash_in),
    .core_data_in      (core_data_in),
    .core_output_valid (core_output_valid),
    .core_hash_out     (core_hash_out),
    .digest_valid      (digest_valid),
    .digest_ready      (digest_ready),
    .digest            (digest),
    .digest_err        (digest_err),
    .busy              (busy),
    .msg_count         (msg_count),
    .blk_count         (blk_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_msg  = 0;
  int exp_blk  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // ---------------- reference SHA-256 compression ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // ---------------- core model: restarts on input_valid, answers 65 cycles later ----------------
  logic model_valid = 1'b0;
  logic stray = 1'b0;
  bit   core_dead = 1'b0;
  int   core_cnt = 0;

  always @(posedge clk) begin
    model_valid <= 1'b0;
    if (core_input_valid) begin
      core_cnt = 64;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0 && !core_dead) begin
        model_valid   <= 1'b1;
        core_hash_out <= compress(core_hash_in, core_data_in);
      end
    end
  end

  assign core_output_valid = model_valid | stray;

  // ---------------- scoreboard + monitor ----------------
  typedef struct packed {
    logic [255:0] digest;
    logic         err;
    int           rise;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  logic prev_dv = 1'b0;
  int   rise_cyc = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_dv = 1'b0;
    end else begin
      if (digest_valid && !prev_dv) rise_cyc = cyc;
      prev_dv = digest_valid;
      if (digest_valid && digest_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_digest: got %h err %0d with nothing expected", digest, digest_err);
        end else begin
          mon_e = sb.pop_front();
          check("digest", digest, mon_e.digest);
          check("digest_err", 256'(digest_err), 256'(mon_e.err));
          check("digest_valid_cycle", 256'(rise_cyc), 256'(mon_e.rise));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_block(input logic [511:0] d, input bit last, input bit stray_start, output int a);
    int guard = 0;
    blk_data  = d;
    blk_last  = last;
    blk_valid = 1'b1;
    while (!blk_ready && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) begin
      n_checks++;
      $display("FAIL blk_accept: blk_ready stayed 0 for %0d cycles, required 1", guard);
    end
    a = cyc;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    if (stray_start) begin
      stray = 1'b1;
      @(posedge clk); #1;
      stray = 1'b0;
    end
  endtask

  task automatic send_msg(input logic [511:0] blks [$], input bit use_kat, input logic [255:0] kat,
                          input bit dead, input bit stray_start);
    logic [255:0] h;
    int a;
    exp_t e;
    h = SHA256_IV;
    core_dead = dead;
    for (int i = 0; i < blks.size(); i++) begin
      h = compress(h, blks[i]);
      send_block(blks[i], i == blks.size() - 1, stray_start && i == 0, a);
      if (!dead) exp_blk++;
    end
    e.digest = dead ? 256'h0 : (use_kat ? kat : h);
    e.err    = dead;
    e.rise   = dead ? a + 2 + TIMEOUT : a + 67;
    sb.push_back(e);
    if (!dead) exp_msg++;
  endtask

  task automatic check_counters(input string tag);
    int guard = 0;
    while ((busy || !blk_ready) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) begin
      n_checks++;
      $display("FAIL %s_idle: busy=%0d blk_ready=%0d after %0d cycles, required 0/1", tag, busy, blk_ready, guard);
    end
    check({tag, "_msg_count"}, 256'(msg_count), 256'(exp_msg));
    check({tag, "_blk_count"}, 256'(blk_count), 256'(exp_blk));
  endtask

  task automatic wait_digest_valid(input string tag);
    int guard = 0;
    while (!digest_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL %s_wait: digest_valid stayed 0 for %0d cycles, required 1", tag, guard);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"}, 256'(blk_ready), 256'(1));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
    check({tag, "_digest"}, digest, 256'(0));
    check({tag, "_digest_err"}, 256'(digest_err), 256'(0));
    check({tag, "_msg_count"}, 256'(msg_count), 256'(0));
    check({tag, "_blk_count"}, 256'(blk_count), 256'(0));
    check({tag, "_core_input_valid"}, 256'(core_input_valid), 256'(0));
    check({tag, "_core_hash_in"}, core_hash_in, SHA256_IV);
    check({tag, "_core_data_in"}, core_data_in[255:0] | core_data_in[511:256], 256'(0));
  endtask

  // ---------------- main sequence ----------------
  logic [511:0] abc_blk, two_blk0, two_blk1, rnd_blk;
  logic [511:0] q [$];
  int a_rst;

  initial begin
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    two_blk0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_blk1 = '0;
    two_blk1[31:0] = 32'h000001c0;

    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Stray completion pulses while idle
    stray = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    stray = 1'b0;
    @(posedge clk); #1;
    check("idle_stray_digest_valid", 256'(digest_valid), 256'(0));
    check_counters("idle_stray");

    q = '{abc_blk};
    send_msg(q, 1, ABC_DIGEST, 0, 0);
    check_counters("abc");

    // Two-block message followed back-to-back by "abc" (IV must be reused)
    q = '{two_blk0, two_blk1};
    send_msg(q, 1, TWO_DIGEST, 0, 0);
    q = '{abc_blk};
    send_msg(q, 1, ABC_DIGEST, 0, 0);
    check_counters("two_then_abc");

    // Backpressure with stray pulses in START and OUT
    digest_ready = 1'b0;
    q = '{abc_blk};
    send_msg(q, 1, ABC_DIGEST, 0, 1);
    wait_digest_valid("stall");
    for (int k = 0; k < 10; k++) begin
      check($sformatf("stall%0d_digest", k), digest, ABC_DIGEST);
      check($sformatf("stall%0d_blk_ready", k), 256'(blk_ready), 256'(0));
      check($sformatf("stall%0d_busy", k), 256'(busy), 256'(1));
      check($sformatf("stall%0d_digest_valid", k), 256'(digest_valid), 256'(1));
      stray = (k == 5);
      @(posedge clk); #1;
    end
    stray = 1'b0;
    check("stall_counters_msg", 256'(msg_count), 256'(exp_msg - 1));
    digest_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_digest_valid", 256'(digest_valid), 256'(0));
    check("stall_release_blk_ready", 256'(blk_ready), 256'(1));
    check_counters("stall");

    // Random multi-block messages
    for (int m = 0; m < 4; m++) begin
      q = {};
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        for (int w = 0; w < 16; w++) rnd_blk[w*32 +: 32] = $urandom();
        q.push_back(rnd_blk);
      end
      send_msg(q, 0, 256'h0, 0, 0);
    end
    check_counters("random");

    // Core that never answers: watchdog timeout
    q = '{abc_blk};
    send_msg(q, 0, 256'h0, 1, 0);
    check_counters("timeout");
    core_dead = 1'b0;

    q = '{abc_blk};
    send_msg(q, 1, ABC_DIGEST, 0, 0);
    check_counters("after_timeout");

    // Reset at RUN cycle 30 of block 1 of a two-block message
    send_block(two_blk0, 0, 0, a_rst);
    while (cyc < a_rst + 32) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_msg = 0;
    exp_blk = 0;
    @(posedge clk); #1;
    q = '{abc_blk};
    send_msg(q, 1, ABC_DIGEST, 0, 0);
    check_counters("after_reset");

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "global timeout");
  end

endmodule
